// File: rtl/imem_loader_if.sv
// Byte-stream and imem write-port bundle for the program loader.
// master: loader side (drives rx_ready and the imem write port); slave: byte source / imem side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: length (4B LE), words (4B LE each), checksum byte.
// Ports: clk, rst (sync, high), start, bus (rx stream + imem write), core_hold,
//   busy, done, err, word_cnt (words written in the current load).
module imem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                core_hold,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_WIDTH:0] word_cnt
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_SUM, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0] LP_MAX = 32'(MAX_WORDS);
  localparam logic [ADDR_WIDTH:0] LP_ONE = (ADDR_WIDTH+1)'(1);

  state_t r_state, w_next;

  logic [1:0]            r_bidx;
  logic [31:0]           r_len;
  logic [DATA_WIDTH-1:0] r_word;
  logic [7:0]            r_sum;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_hold;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH:0]   r_cnt;

  logic                  w_rdy;
  logic                  w_xfer;
  logic                  w_last_byte;
  logic [31:0]           w_len;
  logic                  w_len_bad;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_sum;
  logic                  w_sum_ok;
  logic [ADDR_WIDTH:0]   w_cnt_nxt;
  logic                  w_last_word;

  always_comb begin
    w_rdy       = (r_state == S_LEN) ||
                  (r_state == S_DATA) ||
                  (r_state == S_SUM);
    w_xfer      = w_rdy & bus.rx_valid;
    w_last_byte = (r_bidx == 2'd3);
    // Bytes enter at the top and shift down: LSB-first order.
    w_len       = {bus.rx_data, r_len[31:8]};
    w_len_bad   = (w_len == 32'd0) || (w_len > LP_MAX);
    w_word      = {bus.rx_data, r_word[DATA_WIDTH-1:8]};
    w_sum       = r_sum + bus.rx_data;
    w_sum_ok    = (w_sum == 8'd0);
    w_cnt_nxt   = r_cnt + LP_ONE;
    // The word being completed now is word N-1.
    w_last_word = (32'(w_cnt_nxt) == r_len);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR:
        if (start) w_next = S_LEN;
      S_LEN:
        if (w_xfer && w_last_byte)
          w_next = w_len_bad ? S_ERR : S_DATA;
      S_DATA:
        if (w_xfer && w_last_byte && w_last_word)
          w_next = S_SUM;
      S_SUM:
        if (w_xfer) w_next = w_sum_ok ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bidx  <= '0;
      r_len   <= '0;
      r_word  <= '0;
      r_sum   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_bidx <= '0;
            r_len  <= '0;
            r_word <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_hold <= 1'b1;
            r_done <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            r_len  <= w_len;
            r_bidx <= r_bidx + 2'd1;
            if (w_last_byte && w_len_bad) r_err <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word <= w_word;
            r_sum  <= w_sum;
            r_bidx <= r_bidx + 2'd1;
            if (w_last_byte) begin
              r_we    <= 1'b1;
              r_addr  <= LP_BASE + r_cnt[ADDR_WIDTH-1:0];
              r_wdata <= w_word;
              r_cnt   <= w_cnt_nxt;
            end
          end
        end
        S_SUM: begin
          if (w_xfer) begin
            if (w_sum_ok) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready  = w_rdy;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign busy          = w_rdy;
  assign core_hold     = r_hold;
  assign done          = r_done;
  assign err           = r_err;
  assign word_cnt      = r_cnt;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: cycle table for a clean load, then load/error/reset sequences.
// Two instances share the stimulus; the second uses BASE_ADDR=0x100.
module tb_imem_loader;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
  imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

  assign ifb.rx_data  = ifa.rx_data;
  assign ifb.rx_valid = ifa.rx_valid;

  logic hold_a, busy_a, done_a, err_a;
  logic hold_b, busy_b, done_b, err_b;
  logic [AW:0] cnt_a, cnt_b;

  imem_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BASE_ADDR(0), .MAX_WORDS(4096)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .bus(ifa.master),
    .core_hold(hold_a), .busy(busy_a), .done(done_a),
    .err(err_a), .word_cnt(cnt_a)
  );

  imem_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BASE_ADDR(12'h100), .MAX_WORDS(4096)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .bus(ifb.master),
    .core_hold(hold_b), .busy(busy_b), .done(done_b),
    .err(err_b), .word_cnt(cnt_b)
  );

  logic [AW+DW-1:0] qa[$];
  logic [AW+DW-1:0] qb[$];

  always @(negedge clk) begin
    if (ifa.mem_we) qa.push_back({ifa.mem_addr, ifa.mem_wdata});
    if (ifb.mem_we) qb.push_back({ifb.mem_addr, ifb.mem_wdata});
  end

  int errors = 0;
  int checks = 0;

  logic [31:0] wexp [2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    ifa.rx_valid = 1'b0;
    repeat (gap) tick();
    ifa.rx_valid = 1'b1;
    ifa.rx_data  = b;
    while (!ifa.rx_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ifa.rx_ready) begin
      errors++;
      checks++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    tick();
    ifa.rx_valid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], gaps ? int'($urandom_range(5, 1)) : 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load(input logic [7:0] c, input bit gaps);
    send_w(32'd2, gaps);
    send_w(wexp[0], gaps);
    send_w(wexp[1], gaps);
    send_byte(c, gaps ? int'($urandom_range(5, 1)) : 0);
  endtask

  task automatic chk_state(input string nm, input logic d, input logic e,
                           input logic h, input logic b,
                           input logic [AW:0] c);
    chk(nm, 64'({done_a, err_a, hold_a, busy_a, cnt_a}),
        64'({d, e, h, b, c}));
  endtask

  task automatic chk_writes(input string nm, input int n);
    chk({nm, "_nwr_a"}, 64'(qa.size()), 64'(n));
    chk({nm, "_nwr_b"}, 64'(qb.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < qa.size())
        chk({nm, "_wr_a"}, 64'(qa[i]), 64'({AW'(i), wexp[i]}));
      if (i < qb.size())
        chk({nm, "_wr_b"}, 64'(qb[i]), 64'({AW'(12'h100 + i), wexp[i]}));
    end
  endtask

  task automatic clr();
    qa.delete();
    qb.delete();
  endtask

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [12:0] cnt;
  } vec_t;

  function automatic vec_t v(
    input logic st, input logic vld, input logic [7:0] d,
    input logic rdy, input logic we, input logic [11:0] addr,
    input logic [31:0] wd, input logic hold, input logic busy,
    input logic done, input logic err, input logic [12:0] cnt);
    vec_t r;
    r.st = st; r.vld = vld; r.d = d;
    r.rdy = rdy; r.we = we; r.addr = addr; r.wd = wd;
    r.hold = hold; r.busy = busy; r.done = done;
    r.err = err; r.cnt = cnt;
    return r;
  endfunction

  vec_t tbl [17];

  initial begin
    logic [62:0] act;
    logic [62:0] exp;
    wexp[0] = 32'h0010_0513;
    wexp[1] = 32'h0020_0593;
    ifa.rx_valid = 1'b0;
    ifa.rx_data  = 8'h00;

    tbl[0]  = v(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = v(0, 1, 8'h02, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[2]  = v(0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[3]  = v(0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[4]  = v(0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[5]  = v(0, 1, 8'h13, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[6]  = v(0, 1, 8'h05, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[7]  = v(0, 1, 8'h10, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[8]  = v(0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[9]  = v(0, 1, 8'h93, 1, 1, 0, 32'h00100513, 1, 1, 0, 0, 1);
    tbl[10] = v(0, 1, 8'h05, 1, 0, 0, 32'h00100513, 1, 1, 0, 0, 1);
    tbl[11] = v(0, 1, 8'h20, 1, 0, 0, 32'h00100513, 1, 1, 0, 0, 1);
    tbl[12] = v(0, 1, 8'h00, 1, 0, 0, 32'h00100513, 1, 1, 0, 0, 1);
    tbl[13] = v(0, 1, 8'h20, 1, 1, 1, 32'h00200593, 1, 1, 0, 0, 2);
    tbl[14] = v(0, 0, 8'h00, 0, 0, 1, 32'h00200593, 0, 0, 1, 0, 2);
    tbl[15] = v(1, 0, 8'h00, 0, 0, 1, 32'h00200593, 0, 0, 1, 0, 2);
    tbl[16] = v(0, 0, 8'h00, 1, 0, 1, 32'h00200593, 1, 1, 0, 0, 0);

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    clr();

    for (int i = 0; i < 17; i++) begin
      start        = tbl[i].st;
      ifa.rx_valid = tbl[i].vld;
      ifa.rx_data  = tbl[i].d;
      #1;
      act = {ifa.rx_ready, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata,
             hold_a, busy_a, done_a, err_a, cnt_a};
      exp = {tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wd,
             tbl[i].hold, tbl[i].busy, tbl[i].done, tbl[i].err,
             tbl[i].cnt};
      chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
      tick();
    end
    start = 1'b0;
    ifa.rx_valid = 1'b0;
    chk_writes("s1", 2);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_state("s1_reset", 0, 0, 1, 0, 0);

    clr();
    do_start();
    load(8'h21, 0);
    chk_state("s2_bad_sum", 0, 1, 1, 0, 2);
    idle(2);
    chk_writes("s2", 2);

    clr();
    do_start();
    send_w(32'h0000_0000, 0);
    chk_state("s3_len0", 0, 1, 1, 0, 0);
    idle(3);
    chk("s3_len0_nwr", 64'(qa.size()), 64'd0);

    do_start();
    chk("s3_err_clr", 64'(err_a), 64'd0);
    send_w(32'h0000_1001, 0);
    chk_state("s3_len1001", 0, 1, 1, 0, 0);

    do_start();
    send_w(32'h0000_1000, 0);
    chk_state("s3_len1000", 0, 0, 1, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    clr();
    do_start();
    load(8'h20, 1);
    chk_state("s4_gaps", 1, 0, 0, 0, 2);
    idle(2);
    chk_writes("s4", 2);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr();
    do_start();
    send_w(32'd2, 0);
    send_w(wexp[0], 0);
    send_byte(8'h93, 0);
    send_byte(8'h05, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_state("s5_rst", 0, 0, 1, 0, 0);
    chk("s5_rst_we", 64'(ifa.mem_we), 64'd0);
    idle(4);
    chk("s5_nwr", 64'(qa.size()), 64'd1);
    clr();
    do_start();
    load(8'h20, 0);
    chk_state("s5_reload", 1, 0, 0, 0, 2);
    idle(2);
    chk_writes("s5r", 2);

    chk("s6_hold_b_done", 64'(hold_b), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_state("s6_restart", 0, 0, 1, 1, 0);
    chk("s6_hold_b", 64'(hold_b), 64'd1);
    clr();
    load(8'h20, 0);
    chk("s6_done_b", 64'({done_b, err_b, cnt_b}), 64'({2'b10, 13'd2}));
    idle(2);
    chk_writes("s6", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
